// File: rtl/power_telemetry_tx.sv
`default_nettype none
// ============================================================================
// Module   : power_telemetry_tx
// Brief    : Windowed average/peak of x2-scaled converter codes, sent as a
//            4-byte 8N1 frame (sync, avg, peak, checksum).
// Revision : 1.0
// ============================================================================
module power_telemetry_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WINDOW_LOG2  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       tx,
  output logic       tx_busy,
  output logic       overrun
);

  localparam int c_ACC_W  = 8 + WINDOW_LOG2;
  localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [7:0] c_SYNC = 8'hA5;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [c_ACC_W-1:0]     r_acc;
  logic [7:0]             r_peak;
  logic [WINDOW_LOG2-1:0] r_count;
  logic                   r_overrun;

  state_t                 r_state, w_state_n;
  logic [c_BAUD_W-1:0]    r_baud, w_baud_n;
  logic [2:0]             r_bit, w_bit_n;
  logic [1:0]             r_byte, w_byte_n;
  logic [31:0]            r_frame;
  logic                   r_tx, r_busy;
  logic                   w_load;

  logic [c_ACC_W-1:0]     w_sum;
  logic [7:0]             w_avg, w_pk, w_b1, w_b2, w_b3;
  logic [31:0]            w_frame_new, w_frame_sel;
  logic                   w_close, w_baud_done, w_tx_n;

  assign w_sum   = r_acc + {{WINDOW_LOG2{1'b0}}, sample_in};
  assign w_avg   = 8'(w_sum >> WINDOW_LOG2);
  assign w_pk    = (sample_in > r_peak) ? sample_in : r_peak;
  assign w_close = sample_valid && (r_count == '1);

  // Halving undoes the converter's x2 scaling to report input-referred codes
  assign w_b1        = w_avg >> 1;
  assign w_b2        = w_pk >> 1;
  assign w_b3        = c_SYNC ^ w_b1 ^ w_b2;
  assign w_frame_new = {w_b3, w_b2, w_b1, c_SYNC};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_acc     <= '0;
      r_peak    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (sample_valid) begin
        if (w_close) begin
          r_acc   <= '0;
          r_peak  <= '0;
          r_count <= '0;
        end else begin
          r_acc   <= w_sum;
          r_peak  <= w_pk;
          r_count <= r_count + 1'b1;
        end
      end
      if (w_close && (r_state != S_IDLE))
        r_overrun <= 1'b1;
    end
  end

  assign w_baud_done = (r_baud == c_BAUD_LAST);

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud + 1'b1;
    w_bit_n   = r_bit;
    w_byte_n  = r_byte;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_n = '0;
        if (w_close) begin
          w_state_n = S_START;
          w_bit_n   = '0;
          w_byte_n  = '0;
          w_load    = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) w_state_n = S_STOP;
          else               w_bit_n   = r_bit + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_n = '0;
          if (r_byte == 2'd3) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_START;
            w_byte_n  = r_byte + 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Line level is derived from the next state so tx stays a plain register
  assign w_frame_sel = w_load ? w_frame_new : r_frame;
  always_comb begin
    w_tx_n = 1'b1;
    case (w_state_n)
      S_START: w_tx_n = 1'b0;
      S_DATA:  w_tx_n = w_frame_sel[{w_byte_n, w_bit_n}];
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_frame <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_byte  <= w_byte_n;
      if (w_load) r_frame <= w_frame_new;
      r_tx    <= w_tx_n;
      r_busy  <= (w_state_n != S_IDLE);
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_power_telemetry_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_power_telemetry_tx
// Brief    : Randomized self-checking bench; a UART receiver decodes the line
//            and frames are compared against a window-level arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_power_telemetry_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] sample_a, sample_b;
  logic       valid_a, valid_b;
  logic       tx_a, busy_a, ovr_a, tx_b, busy_b, ovr_b;

  power_telemetry_tx #(.CLKS_PER_BIT(4), .WINDOW_LOG2(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_a), .sample_valid(valid_a),
    .tx(tx_a), .tx_busy(busy_a), .overrun(ovr_a)
  );

  power_telemetry_tx u_dut_b (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_b), .sample_valid(valid_b),
    .tx(tx_b), .tx_busy(busy_b), .overrun(ovr_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic sel_b = 1'b0;
  logic tx_mon, busy_mon;
  int   cpb_mon;
  assign tx_mon   = sel_b ? tx_b : tx_a;
  assign busy_mon = sel_b ? busy_b : busy_a;
  assign cpb_mon  = sel_b ? 16 : 4;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int busy_run = 0;
  int last_busy_len = 0;

  always @(negedge clk) begin
    if (busy_mon === 1'b1) begin
      busy_run <= busy_run + 1;
    end else if (busy_run > 0) begin
      last_busy_len <= busy_run;
      busy_run <= 0;
    end
  end

  // 8N1 receiver sampling mid-bit
  initial begin : p_rx
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_mon === 1'b0) begin
        repeat (cpb_mon / 2) @(negedge clk);
        chk("rx_start", tx_mon, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (cpb_mon) @(negedge clk);
          b[i] = tx_mon;
        end
        repeat (cpb_mon) @(negedge clk);
        chk("rx_stop", tx_mon, 1);
        rx_q.push_back(b);
      end
    end
  end

  logic [7:0] win[256];

  task automatic send_window(input int n, input int gapmax, input bit expect_sent);
    int sum, pk;
    logic [7:0] b1, b2;
    sum = 0;
    pk  = 0;
    for (int i = 0; i < n; i++) begin
      if (sel_b) begin sample_b = win[i]; valid_b = 1'b1; end
      else       begin sample_a = win[i]; valid_a = 1'b1; end
      @(negedge clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
      if (i != n - 1 && gapmax > 0)
        repeat ($urandom_range(gapmax, 0)) @(negedge clk);
      sum += int'(win[i]);
      if (int'(win[i]) > pk) pk = int'(win[i]);
    end
    if (expect_sent) begin
      b1 = 8'((sum / n) / 2);
      b2 = 8'(pk / 2);
      exp_q.push_back(8'hA5);
      exp_q.push_back(b1);
      exp_q.push_back(b2);
      exp_q.push_back(8'hA5 ^ b1 ^ b2);
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy_mon !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, int'(t < 2000), 1);
    repeat (3 * cpb_mon) @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic fill4(input logic [7:0] a, b, c, d);
    win[0] = a; win[1] = b; win[2] = c; win[3] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowlen;
    rst_n = 1'b1; valid_a = 1'b0; valid_b = 1'b0; sample_a = '0; sample_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_ovr_a", ovr_a, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_busy_b", busy_b, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Consecutive samples; line drops right after the closing edge
    fill4(8'h10, 8'h20, 8'h30, 8'h40);
    send_window(4, 0, 1'b1);
    chk("t1_tx_low", tx_a, 0);
    chk("t1_busy", busy_a, 1);
    wait_idle("t1_idle");
    chk("t1_busy_len", last_busy_len, 160);
    chk("t1_ovr", ovr_a, 0);
    check_frames("t1");

    // Gaps between valid samples
    fill4(8'hFE, 8'hFE, 8'hFE, 8'hFE);
    send_window(4, 3, 1'b1);
    wait_idle("t2_idle");
    check_frames("t2");

    // Window closing mid-frame is dropped
    for (int i = 0; i < 4; i++) win[i] = 8'($urandom);
    send_window(4, 0, 1'b1);
    repeat (46) @(negedge clk);
    fill4(8'h02, 8'h02, 8'h02, 8'h02);
    send_window(4, 0, 1'b0);
    chk("t3_ovr_set", ovr_a, 1);
    wait_idle("t3_idle");
    check_frames("t3");
    for (int i = 0; i < 4; i++) win[i] = 8'($urandom);
    send_window(4, 0, 1'b1);
    wait_idle("t3b_idle");
    check_frames("t3b");
    chk("t3_ovr_sticky", ovr_a, 1);

    // Close on the last stop-bit cycle is still an overrun
    pulse_reset();
    for (int i = 0; i < 4; i++) win[i] = 8'($urandom);
    send_window(4, 0, 1'b1);
    repeat (156) @(negedge clk);
    for (int i = 0; i < 4; i++) win[i] = 8'($urandom);
    send_window(4, 0, 1'b0);
    chk("tb_last_stop_ovr", ovr_a, 1);
    wait_idle("tb_idle1");
    check_frames("tb1");

    // One cycle later the FSM is idle: back-to-back frame accepted
    pulse_reset();
    for (int i = 0; i < 4; i++) win[i] = 8'($urandom);
    send_window(4, 0, 1'b1);
    repeat (157) @(negedge clk);
    for (int i = 0; i < 4; i++) win[i] = 8'($urandom);
    send_window(4, 0, 1'b1);
    chk("tb_b2b_ovr", ovr_a, 0);
    wait_idle("tb_idle2");
    chk("tb_b2b_busy_len", last_busy_len, 160);
    check_frames("tb2");

    // Reset during byte 1 data bits aborts frame and clears everything
    for (int i = 0; i < 4; i++) win[i] = 8'($urandom);
    send_window(4, 0, 1'b0);
    repeat (10) @(negedge clk);
    send_window(4, 0, 1'b0);
    repeat (20) @(negedge clk);
    win[0] = 8'hFF; win[1] = 8'hFF;
    send_window(2, 0, 1'b0);
    repeat (10) @(negedge clk);
    chk("t4_ovr_pre", ovr_a, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_rst_tx", tx_a, 1);
    chk("t4_rst_busy", busy_a, 0);
    chk("t4_rst_ovr", ovr_a, 0);
    rst_n = 1'b0;
    repeat (60) @(negedge clk);
    rx_q.delete();
    exp_q.delete();
    fill4(8'h08, 8'h08, 8'h08, 8'h08);
    send_window(4, 0, 1'b1);
    wait_idle("t4_idle");
    check_frames("t4");

    // Floor on the average
    fill4(8'h00, 8'h00, 8'h00, 8'h06);
    send_window(4, 0, 1'b1);
    wait_idle("t5_idle");
    check_frames("t5");

    // Random windows, even codes as the converter produces
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 4; i++) win[i] = 8'($urandom) & 8'hFE;
      send_window(4, 3, 1'b1);
      wait_idle("rnd_idle");
      check_frames($sformatf("rnd%0d", w));
    end
    chk("rnd_ovr", ovr_a, 0);

    // Default parameters: 16-sample ramp
    sel_b = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) win[i] = 8'(2 * i);
    send_window(16, 0, 1'b1);
    lowlen = 0;
    while (tx_b === 1'b0 && lowlen < 100) begin
      lowlen++;
      @(negedge clk);
    end
    chk("t6_start_len", lowlen, 16);
    wait_idle("t6_idle");
    chk("t6_busy_len", last_busy_len, 640);
    chk("t6_ovr", ovr_b, 0);
    check_frames("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/power_telemetry_tx.md
Name: power_telemetry_tx

Overview:
- Far-end consumer of the power converter's scaled output code (output = 2 × input, LSB always 0).
- Accumulates a window of converter output samples and undoes the ×2 scaling to recover input-referred values.
- Sends a 4-byte telemetry frame (sync, average, peak, checksum) over a UART-style 8N1 serial line to the off-chip data logger.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be ≥2.
- WINDOW_LOG2, 4: window length is 2^WINDOW_LOG2 accepted samples; range 1..8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-high reset (asserted = 1), sampled on rising clk.
- sample_in  input  8  converter output code (×2 scaled).
- sample_valid  input  1  sample_in is accepted on any rising edge where this is 1.
- tx  output  1  serial line, idle high, 8N1, LSB first.
- tx_busy  output  1  high while a frame is being shifted out.
- overrun  output  1  sticky flag: a completed window was dropped because the transmitter was busy.

Behaviour:
- Reset (rst_n = 1 at an edge) sets the following, and has priority over every other event:
  - tx = 1, tx_busy = 0, overrun = 0.
  - Accumulator, peak, sample count, bit counter, baud counter and FSM all cleared; FSM returns to IDLE.
  - A reset in the middle of a frame aborts it. tx returns high on the next edge and no partial byte is completed.
- Accumulation:
  - On each accepted sample:
    - acc += sample_in, with acc width 8+WINDOW_LOG2, so it never overflows.
    - peak = max(peak, sample_in).
    - count += 1.
  - Cycles with sample_valid = 0 change nothing.
- Window close: occurs on the edge that accepts sample number 2^WINDOW_LOG2.
  - avg = (acc + sample_in) >> WINDOW_LOG2, truncated (floor).
  - pk = max(peak, sample_in).
  - acc, peak and count are cleared on the same edge, so the next valid sample starts a fresh window with no gap.
- Frame build, on window close when the FSM is IDLE:
  - Byte0 = 0xA5.
  - Byte1 = avg >> 1.
  - Byte2 = pk >> 1.
  - Byte3 = Byte0 ^ Byte1 ^ Byte2.
  - All four bytes are latched; tx_busy = 1 from the next edge.
- Window close when the FSM is not IDLE, including the last stop-bit cycle:
  - The window result is discarded and overrun is set to 1.
  - The frame in flight is unaffected.
  - overrun clears only on reset.
- Serial FSM states: IDLE → START → DATA → STOP → (START for next byte | IDLE).
  - IDLE: tx = 1. On frame load go to START, byte index = 0, baud counter = 0.
  - START: tx = 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. Then byte index++; if it was 3, go to IDLE and set tx_busy = 0, else go to START.
- Timing:
  - tx first goes low on the edge after window close.
  - A frame lasts exactly 40 × CLKS_PER_BIT cycles, with no idle gap between bytes.
  - tx_busy falls on the same edge the FSM enters IDLE.
- tx and tx_busy are registered outputs, with no combinational path from the inputs.
- Sampling continues normally while transmitting.

Test Plan:
1. CLKS_PER_BIT=4, WINDOW_LOG2=2; samples 0x10, 0x20, 0x30, 0x40 on consecutive cycles.
   - Required: frame bytes A5, 14, 20, 91.
   - Frame is 160 cycles long; tx low on the edge after the 4th sample.
   - tx_busy high for exactly 160 cycles; overrun = 0.
2. Same configuration; four samples of 0xFE with sample_valid gaps of 0–3 cycles between them.
   - Required: bytes A5, 7F, 7F, A5.
   - The gaps do not affect the result.
3. Same configuration; a second window of 0x02 ×4 completes at cycle 50 of the first frame.
   - Required: first frame transmitted intact, overrun = 1, and no second frame.
   - A third window completing after tx_busy falls is transmitted; overrun stays 1.
4. Same configuration; rst_n = 1 for one cycle during the DATA bits of Byte1.
   - Required: tx = 1, tx_busy = 0 and overrun = 0 on the next edge.
   - A subsequent window 0x08 ×4 produces A5, 04, 04, A5.
5. Same configuration; window 0x00, 0x00, 0x00, 0x06.
   - Required: avg = 0x01 (floor), frame A5, 00, 03, A6.
6. Defaults (CLKS_PER_BIT=16, WINDOW_LOG2=4); 16 samples ramping 0x00..0x1E step 2.
   - Required: avg 0x0F → 0x07, pk 0x1E → 0x0F, checksum 0xAD.
   - Each bit is held exactly 16 cycles.
